// File: rtl/tb_pkg.sv
// tb_pkg: shared types and constants for the trace-buffer dump controller.
// Holds the readout FSM state encoding and the lane-index width helper.
package tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FREEZE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } tb_dump_state_t;

  function automatic int tb_lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TB_LANE_W = tb_lane_w(8);

endpackage

// File: rtl/tb_dump_ctrl.sv
// tb_dump_ctrl: freezes tracing, walks the circular trace buffer oldest to
// newest and serializes each N-lane entry onto a valid/ready word stream.
module tb_dump_ctrl
  import tb_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dump_start,
  input  logic [$clog2(TB_SIZE)-1:0]    wr_ptr,
  input  logic                          wr_wrapped,
  output logic                          tracing,
  output logic                          rd_en,
  output logic [$clog2(TB_SIZE)-1:0]    rd_addr,
  input  logic [N*DATA_WIDTH-1:0]       rd_data,
  output logic [DATA_WIDTH-1:0]         dump_data,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic                          dump_last,
  output logic                          dump_busy,
  output logic                          dump_done
);

  localparam int AW = $clog2(TB_SIZE);
  localparam int CW = AW + 1;
  localparam int LW = tb_lane_w(N);
  localparam int WW = $clog2(RD_LATENCY + 1);

  tb_dump_state_t state_q, state_d;

  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] idx_inc;
  logic [LW-1:0] lane_q, lane_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [N-1:0][DATA_WIDTH-1:0] data_q, data_d;

  assign idx_inc = idx_q + CW'(1);

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  // Next-state, datapath updates and all outputs, decoded from the state.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    wait_d     = wait_q;
    data_d     = data_q;
    tracing    = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    dump_data  = '0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    dump_busy  = 1'b1;
    dump_done  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tracing   = 1'b1;
        dump_busy = 1'b0;
        if (dump_start) begin
          state_d = S_FREEZE;
        end
      end

      // Tracing is already off here, so the last enqueue has landed
      // by the time the pointers are snapshotted at the cycle end.
      S_FREEZE: begin
        idx_d = '0;
        if (wr_wrapped) begin
          base_d  = wr_ptr;
          count_d = CW'(TB_SIZE);
          state_d = S_READ;
        end else begin
          base_d  = '0;
          count_d = {1'b0, wr_ptr};
          state_d = (wr_ptr != '0) ? S_READ : S_DONE;
        end
      end

      S_READ: begin
        rd_en   = 1'b1;
        rd_addr = base_q + idx_q[AW-1:0];
        wait_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == WW'(RD_LATENCY - 1)) begin
          data_d  = rd_data;
          lane_d  = '0;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      S_SEND: begin
        dump_valid = 1'b1;
        dump_data  = data_q[lane_q];
        dump_last  = (lane_q == LW'(N - 1)) &&
                     (idx_inc == count_q);
        if (dump_ready) begin
          if (lane_q == LW'(N - 1)) begin
            idx_d   = idx_inc;
            state_d = (idx_inc < count_q) ? S_READ : S_DONE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end

      S_DONE: begin
        dump_done = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tb_dump_ctrl.sv
// tb_tb_dump_ctrl: randomized checks of the dump controller against a
// queue-based model of the oldest-to-newest buffer walk.
module tb_tb_dump_ctrl;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TS = 64;
  localparam int L  = 1;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic          dump_start;
  logic [AW-1:0] wr_ptr;
  logic          wr_wrapped;
  logic          dump_ready;
  logic          tracing;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N*DW-1:0] rd_data;
  logic [DW-1:0] dump_data;
  logic          dump_valid;
  logic          dump_last;
  logic          dump_busy;
  logic          dump_done;

  logic [N*DW-1:0] mem [TS];

  int total;
  int bad;

  tb_dump_ctrl #(
    .N(N),
    .DATA_WIDTH(DW),
    .TB_SIZE(TS),
    .RD_LATENCY(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dump_start(dump_start),
    .wr_ptr(wr_ptr),
    .wr_wrapped(wr_wrapped),
    .tracing(tracing),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .dump_data(dump_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_last(dump_last),
    .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B of the trace buffer: one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tracing"}, tracing, 1'b1);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, '0);
    chk({tag, "_valid"}, dump_valid, 1'b0);
    chk({tag, "_last"}, dump_last, 1'b0);
    chk({tag, "_busy"}, dump_busy, 1'b0);
    chk({tag, "_done"}, dump_done, 1'b0);
    chk({tag, "_data"}, dump_data, '0);
  endtask

  task automatic run_dump(input string tag, input bit wrap, input int ptr,
                          input bit rnd, input int restart_at);
    logic [DW-1:0] exp_w[$];
    logic [DW-1:0] got_w[$];
    int exp_a[$];
    int got_a[$];
    int cnt, base, k, first_k, done_k, done_n, low_n;
    int last_n, last_pos;
    bit stall, fin;
    logic [DW-1:0] hold_d;
    logic hold_l;

    cnt  = wrap ? TS : ptr;
    base = wrap ? ptr : 0;
    for (int e = 0; e < cnt; e++) begin
      int a;
      a = (base + e) % TS;
      exp_a.push_back(a);
      for (int l = 0; l < N; l++) exp_w.push_back(mem[a][l*DW +: DW]);
    end

    wr_wrapped = wrap;
    wr_ptr     = AW'(ptr);
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    k = 1; first_k = -1; done_k = -1; done_n = 0; low_n = 0;
    last_n = 0; last_pos = -1; stall = 0; fin = 0;
    hold_d = '0; hold_l = 1'b0;

    while (!fin && k < 4000) begin
      dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_start = (k == restart_at);
      #1;
      if (!tracing) low_n++;
      if (rd_en) got_a.push_back(int'(rd_addr));
      if (stall) begin
        chk({tag, "_stall_valid"}, dump_valid, 1'b1);
        chk({tag, "_stall_data"}, dump_data, hold_d);
        chk({tag, "_stall_last"}, dump_last, hold_l);
      end
      if (dump_valid && first_k < 0) first_k = k;
      if (dump_valid && dump_ready) begin
        got_w.push_back(dump_data);
        if (dump_last) begin
          last_n++;
          last_pos = got_w.size();
        end
      end
      stall  = dump_valid && !dump_ready;
      hold_d = dump_data;
      hold_l = dump_last;
      if (dump_done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) fin = 1;
      @(negedge clk);
      k++;
    end
    dump_start = 1'b0;

    chk({tag, "_finished"}, fin, 1'b1);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_tracing_after"}, tracing, 1'b1);
    chk({tag, "_busy_after"}, dump_busy, 1'b0);
    chk({tag, "_trace_low"}, low_n, done_k);
    chk({tag, "_words"}, got_w.size(), exp_w.size());
    chk({tag, "_reads"}, got_a.size(), exp_a.size());
    if (got_w.size() == exp_w.size())
      for (int i = 0; i < exp_w.size(); i++)
        chk({tag, "_word"}, got_w[i], exp_w[i]);
    if (got_a.size() == exp_a.size())
      for (int i = 0; i < exp_a.size(); i++)
        chk({tag, "_addr"}, got_a[i], exp_a[i]);
    if (cnt > 0) begin
      chk({tag, "_first_valid"}, first_k, 3 + L);
      chk({tag, "_last_count"}, last_n, 1);
      chk({tag, "_last_pos"}, last_pos, exp_w.size());
    end else begin
      chk({tag, "_no_valid"}, first_k, -1);
      chk({tag, "_done_at"}, done_k, 2);
      chk({tag, "_no_last"}, last_n, 0);
    end
  endtask

  initial begin
    int i;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    dump_start = 1'b0;
    wr_ptr     = '0;
    wr_wrapped = 1'b0;
    dump_ready = 1'b1;
    for (int a = 0; a < TS; a++)
      for (int l = 0; l < N; l++) mem[a][l*DW +: DW] = $urandom();

    @(negedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_dump("partial", 1'b0, 3, 1'b0, 0);
    run_dump("wrapped", 1'b1, 60, 1'b0, 0);
    run_dump("empty", 1'b0, 0, 1'b0, 0);
    run_dump("bp", 1'b0, 5, 1'b1, 0);
    run_dump("bp_wrap", 1'b1, 17, 1'b1, 0);
    run_dump("restart", 1'b0, 2, 1'b0, 10);

    wr_wrapped = 1'b0;
    wr_ptr     = AW'(4);
    dump_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    i = 0;
    while (i < 50 && !dump_valid) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_send", dump_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    #1;
    chk("midrst_no_done", dump_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_dump("after_rst", 1'b0, 7, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_dump_ctrl.md
# tb_dump_ctrl

Readout controller sitting directly downstream of the trace buffer, on its port-B read side. On a dump request it freezes tracing, walks the circular buffer from oldest to newest entry, and serializes each N-lane vector into a DATA_WIDTH-wide valid/ready stream toward the host link. When the dump completes it re-enables tracing.

## Interface
- N, 8, vector lanes per trace-buffer entry
- DATA_WIDTH, 32, bits per lane and per output word
- TB_SIZE, 64, trace-buffer depth in entries (power of two)
- RD_LATENCY, 1, cycles from rd_addr/rd_en to valid rd_data
- AW, $clog2(TB_SIZE), address width (derived, not overridable)
- Reset is asynchronous and active-low; the block has one clock.
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- dump_start  in  1  one-cycle dump request; honoured only in IDLE
- wr_ptr  in  AW  trace-buffer next-write address
- wr_wrapped  in  1  trace buffer has written all TB_SIZE entries at least once
- tracing  out  1  enable to trace buffer; 1 = capture allowed
- rd_en  out  1  port-B read strobe
- rd_addr  out  AW  port-B read address
- rd_data  in  N×DATA_WIDTH  port-B read vector, lane 0 first
- dump_data  out  DATA_WIDTH  serialized output word
- dump_valid  out  1  dump_data valid
- dump_ready  in  1  downstream accepts word when valid&ready
- dump_last  out  1  marks the final word of the dump
- dump_busy  out  1  high in every state except IDLE
- dump_done  out  1  one-cycle pulse when the dump ends

## Operation
- States: IDLE, FREEZE, READ, WAIT, SEND, DONE.
- IDLE: tracing=1; on dump_start, go to FREEZE.
- FREEZE (1 cycle): tracing=0, which lets the final in-flight enqueue land. At the end of the cycle, snapshot the pointers:
  - if wr_wrapped: base=wr_ptr, count=TB_SIZE
  - else: base=0, count=wr_ptr
  - if count==0, go to DONE; else go to READ.
- READ (1 cycle): rd_en=1, rd_addr=(base+idx) mod TB_SIZE, using AW-bit natural wrap. Go to WAIT.
- WAIT: hold for RD_LATENCY cycles, then latch rd_data into the lane register and go to SEND with lane=0.
- SEND: dump_data=lane_reg[lane] and dump_valid=1. On handshake:
  - lane<N-1: lane++
  - else idx++; go to READ if idx<count, otherwise DONE.
  - dump_last=1 only on lane N-1 of entry count-1.
- DONE (1 cycle): dump_done=1, then return to IDLE; tracing returns to 1 in IDLE.
- dump_start outside IDLE is ignored, not queued.
- idx and count are AW+1 bits wide so that count=TB_SIZE is representable.
- dump_data and dump_last stay stable while dump_valid=1 and dump_ready=0.

## Timing
- Reset values: tracing=1, rd_en=0, rd_addr=0, dump_valid=0, dump_last=0, dump_busy=0, dump_done=0, dump_data=0. State returns to IDLE.
- Reset asserted mid-dump aborts immediately. No dump_done is produced; the stream is truncated.
- tracing falls the cycle after dump_start is sampled.
- First dump_valid appears 3+RD_LATENCY cycles after the dump_start edge (FREEZE, READ, WAIT, then SEND).
- Per entry with continuous ready: N words in N cycles, plus 1+RD_LATENCY gap cycles for READ/WAIT.
- An empty buffer gives dump_done 2 cycles after dump_start, with zero words emitted.
- Wrap: a full buffer with wr_ptr=k reads k, k+1, …, TB_SIZE-1, 0, …, k-1.

## Structure
- Shared package tb_pkg holds the state enum tb_dump_state_t and the lane-index width constant.
- Single module with no sub-modules. The serializer lane register is inline.

## Test plan
- Partial fill: wrapped=0, wr_ptr=3, N=8 -> 24 words in order from entries 0,1,2; dump_last on word 24; done pulse; tracing back to 1.
- Wrapped buffer: wrapped=1, wr_ptr=60 -> rd_addr sequence 60,61,62,63,0,…,59; 512 words total.
- Empty buffer: wrapped=0, wr_ptr=0 -> no dump_valid; dump_done 2 cycles after dump_start; tracing low for exactly 2 cycles.
- Backpressure: dump_ready toggles randomly -> dump_data held stable while stalled; word order and count unchanged versus continuous ready.
- dump_start pulsed again mid-dump -> ignored; exactly one dump_done.
- rst_n asserted during SEND -> outputs at reset values the same cycle; a new dump_start afterward performs a full, correct dump.
